// File: rtl/dual_dac_spi_tx.sv
// rtl/dual_dac_spi_tx.sv - serialises X/Y beam codes to a dual 12-bit SPI DAC with a common LDAC strobe
module dual_dac_spi_tx #(
  parameter int         CLK_DIV  = 2,
  parameter logic [2:0] CFG_BITS = 3'b011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] xdac_in,
  input  logic [7:0] ydac_in,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       dac_ldac_n,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW       = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, LDAC} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          cnt_last;
  logic [3:0]    bit_idx, bit_n, mosi_idx;
  logic          high, high_n;
  logic          ch, ch_n;
  logic [7:0]    x_hold, y_hold, x_hold_n, y_hold_n;
  logic [15:0]   word_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    high_n   = high;
    ch_n     = ch;
    x_hold_n = x_hold;
    y_hold_n = y_hold;
    cnt_last = (cnt == CNT_LAST);
    cnt_inc  = cnt_last ? '0 : cnt + CW'(1);
    case (state)
      IDLE: begin
        if (enable) begin
          state_n  = SETUP;
          cnt_n    = '0;
          bit_n    = 4'd15;
          ch_n     = 1'b0;
          x_hold_n = xdac_in;
          y_hold_n = ydac_in;
        end
      end
      SETUP: begin
        cnt_n = cnt_inc;
        if (cnt_last) begin
          state_n = SHIFT;
          high_n  = 1'b1;
        end
      end
      SHIFT: begin
        cnt_n = cnt_inc;
        if (cnt_last) begin
          if (high) begin
            high_n = 1'b0;
          end else if (bit_idx == 4'd0) begin
            state_n = GAP;
          end else begin
            bit_n  = bit_idx - 4'd1;
            high_n = 1'b1;
          end
        end
      end
      GAP: begin
        cnt_n = cnt_inc;
        if (cnt_last) begin
          if (ch) begin
            state_n = LDAC;
          end else begin
            state_n = SETUP;
            ch_n    = 1'b1;
            bit_n   = 4'd15;
          end
        end
      end
      LDAC: begin
        cnt_n = cnt_inc;
        if (cnt_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from next-state values, so mosi leads with the bit
    // about to be sampled; in a LOW phase it already shows the following bit.
    word_n   = {ch_n, CFG_BITS, (ch_n ? y_hold_n : x_hold_n), 4'b0000};
    mosi_idx = (state_n == SHIFT && !high_n && bit_n != 4'd0) ? bit_n - 4'd1 : bit_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 4'd15;
      high       <= 1'b0;
      ch         <= 1'b0;
      x_hold     <= 8'd0;
      y_hold     <= 8'd0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      high       <= high_n;
      ch         <= ch_n;
      x_hold     <= x_hold_n;
      y_hold     <= y_hold_n;
      dac_cs_n   <= !(state_n == SETUP || state_n == SHIFT);
      dac_sclk   <= (state_n == SHIFT) && high_n;
      dac_mosi   <= (state_n == SETUP || state_n == SHIFT) ? word_n[mosi_idx] : 1'b0;
      dac_ldac_n <= (state_n != LDAC);
      busy       <= (state_n != IDLE);
      frame_done <= (state_n == LDAC) && (cnt_n == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_dual_dac_spi_tx.sv
// tb/tb_dual_dac_spi_tx.sv - directed bench for dual_dac_spi_tx at CLK_DIV=2 and CLK_DIV=1
module tb_dual_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic       en_a, cs_a, sclk_a, mosi_a, ldac_a, busy_a, fd_a;
  logic [7:0] x_a, y_a;
  logic       en_b, cs_b, sclk_b, mosi_b, ldac_b, busy_b, fd_b;
  logic [7:0] x_b, y_b;

  dual_dac_spi_tx #(.CLK_DIV(2)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .xdac_in(x_a), .ydac_in(y_a),
    .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a), .dac_ldac_n(ldac_a),
    .busy(busy_a), .frame_done(fd_a)
  );

  dual_dac_spi_tx #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .xdac_in(x_b), .ydac_in(y_b),
    .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b), .dac_ldac_n(ldac_b),
    .busy(busy_b), .frame_done(fd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SPI monitors: decode words per cs_n window, check protocol rules every cycle
  logic [15:0] sh_a, sh_b;
  logic [15:0] words_a[$], words_b[$];
  int  rises_a, rises_b, cs_rise_a, cs_rise_b, ldac_fall_a, ldac_fall_b, ldac_low_a, ldac_low_b;
  logic p_sclk_a = 0, p_cs_a = 1, p_mosi_a = 0, p_ldac_a = 1;
  logic p_sclk_b = 0, p_cs_b = 1, p_mosi_b = 0, p_ldac_b = 1;
  bit  abort_a, abort_b;

  always @(negedge clk) begin
    if (reset) abort_a = 1;
    check("a cs/ldac overlap", {31'd0, cs_a | ldac_a}, 1);
    if (cs_a) check("a sclk idle", {31'd0, sclk_a}, 0);
    if (sclk_a && !p_sclk_a) begin
      if (!cs_a) begin sh_a = {sh_a[14:0], mosi_a}; rises_a++; end
      check("a mosi stable at rise", {31'd0, mosi_a}, {31'd0, p_mosi_a});
    end
    if (!cs_a && p_cs_a) begin rises_a = 0; if (!reset) abort_a = 0; end
    if (cs_a && !p_cs_a) begin
      if (!abort_a) begin check("a rises per window", rises_a, 16); words_a.push_back(sh_a); end
      cs_rise_a = cyc;
    end
    if (!ldac_a && p_ldac_a) begin ldac_fall_a = cyc; ldac_low_a = 0; end
    if (!ldac_a) ldac_low_a++;
    p_sclk_a = sclk_a; p_cs_a = cs_a; p_mosi_a = mosi_a; p_ldac_a = ldac_a;
  end

  always @(negedge clk) begin
    if (reset) abort_b = 1;
    check("b cs/ldac overlap", {31'd0, cs_b | ldac_b}, 1);
    if (cs_b) check("b sclk idle", {31'd0, sclk_b}, 0);
    if (sclk_b && !p_sclk_b) begin
      if (!cs_b) begin sh_b = {sh_b[14:0], mosi_b}; rises_b++; end
      check("b mosi stable at rise", {31'd0, mosi_b}, {31'd0, p_mosi_b});
    end
    if (!cs_b && p_cs_b) begin rises_b = 0; if (!reset) abort_b = 0; end
    if (cs_b && !p_cs_b) begin
      if (!abort_b) begin check("b rises per window", rises_b, 16); words_b.push_back(sh_b); end
      cs_rise_b = cyc;
    end
    if (!ldac_b && p_ldac_b) begin ldac_fall_b = cyc; ldac_low_b = 0; end
    if (!ldac_b) ldac_low_b++;
    p_sclk_b = sclk_b; p_cs_b = cs_b; p_mosi_b = mosi_b; p_ldac_b = ldac_b;
  end

  task automatic drive(input bit sel, input logic en, input logic [7:0] x, input logic [7:0] y);
    if (sel) begin en_b = en; x_b = x; y_b = y; end
    else     begin en_a = en; x_a = x; y_a = y; end
  endtask

  // One enable pulse, then wait (bounded) for frame_done and check words and timing.
  task automatic run_frame(input bit sel, input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] ew0, input logic [15:0] ew1,
                           input bit scramble, input string tag);
    int d, base, fcyc, n;
    bit seen;
    d = sel ? 1 : 2;
    seen = 0;
    fcyc = -1;
    if (sel) words_b.delete(); else words_a.delete();
    @(negedge clk); #1;
    drive(sel, 1'b1, x, y);
    base = cyc;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk); #1;
      if (scramble) drive(sel, 1'b0, 8'($urandom), 8'($urandom));
      else          drive(sel, 1'b0, x, y);
      if (sel ? fd_b : fd_a) begin seen = 1; fcyc = cyc - base; end
    end
    check({tag, " frame_done cycle"}, fcyc, 69 * d);
    n = sel ? words_b.size() : words_a.size();
    check({tag, " word count"}, n, 2);
    if (n >= 2) begin
      check({tag, " X word"}, {16'd0, (sel ? words_b[0] : words_a[0])}, {16'd0, ew0});
      check({tag, " Y word"}, {16'd0, (sel ? words_b[1] : words_a[1])}, {16'd0, ew1});
    end
    check({tag, " ldac delay after cs rise"}, sel ? ldac_fall_b - cs_rise_b : ldac_fall_a - cs_rise_a, d);
    check({tag, " ldac low cycles"}, sel ? ldac_low_b : ldac_low_a, d);
  endtask

  typedef struct {
    bit          sel;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] w0;
    logic [15:0] w1;
    bit          scramble;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   fd_prev, fd_now, n, base, lcount;
    logic [7:0] xv;
    bit   seen;

    vecs[0] = '{0, 8'hA5, 8'h3C, 16'h3A50, 16'hB3C0, 0};
    vecs[1] = '{0, 8'h00, 8'hFF, 16'h3000, 16'hBFF0, 0};
    vecs[2] = '{0, 8'h12, 8'h34, 16'h3120, 16'hB340, 1};
    vecs[3] = '{1, 8'hFF, 8'h00, 16'h3FF0, 16'hB000, 0};
    vecs[4] = '{1, 8'h81, 8'h7E, 16'h3810, 16'hB7E0, 0};

    // Reset held with enable high: outputs must sit at reset values
    reset = 1'b1;
    drive(0, 1'b1, 8'h55, 8'hAA);
    drive(1, 1'b1, 8'h55, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("reset outputs a", {26'd0, cs_a, sclk_a, mosi_a, ldac_a, busy_a, fd_a}, 32'b100100);
      check("reset outputs b", {26'd0, cs_b, sclk_b, mosi_b, ldac_b, busy_b, fd_b}, 32'b100100);
    end
    drive(0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    @(negedge clk); #1;
    check("idle after reset a busy", {31'd0, busy_a}, 0);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].w0, vecs[i].w1,
                vecs[i].scramble, $sformatf("vec%0d", i));

    // Enable held high, X ramps once per frame
    words_a.delete();
    @(negedge clk); #1;
    xv = 8'h40;
    drive(0, 1'b1, xv, 8'h99);
    fd_prev = -1;
    for (int f = 0; f < 3; f++) begin
      seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk); #1;
        if (fd_a) seen = 1;
      end
      check("ramp frame_done seen", {31'd0, seen}, 1);
      fd_now = cyc;
      if (f > 0) check("ramp frame period", fd_now - fd_prev, 139);
      fd_prev = fd_now;
      xv = xv + 8'd1;
      drive(0, (f < 2), xv, 8'h99);
    end
    n = words_a.size();
    check("ramp word count", n, 6);
    for (int k = 0; k < 3 && 2 * k + 1 < n; k++) begin
      check("ramp X word", {16'd0, words_a[2*k]}, {16'd0, 4'h3, 8'(8'h40 + k), 4'h0});
      check("ramp Y word", {16'd0, words_a[2*k+1]}, 32'h0000B990);
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("ramp stops when enable low", {31'd0, busy_a}, 0);

    // Reset during bit 7 of the Y word aborts the frame without LDAC
    @(negedge clk); #1;
    drive(0, 1'b1, 8'h5A, 8'hC3);
    base = cyc;
    for (int i = 0; i < 200 && (cyc - base) < 104; i++) begin
      @(negedge clk); #1;
      drive(0, 1'b0, 8'h5A, 8'hC3);
    end
    check("mid-shift sclk high at bit 7", {31'd0, sclk_a}, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("abort outputs", {29'd0, cs_a, sclk_a, busy_a}, 32'b100);
    check("abort ldac", {31'd0, ldac_a}, 1);
    reset = 1'b0;
    lcount = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk); #1;
      if (!ldac_a || fd_a || busy_a) lcount++;
    end
    check("no activity after abort", lcount, 0);
    run_frame(0, 8'h5A, 8'hC3, 16'h35A0, 16'hBC30, 0, "after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
